regfile_mp: RTL

- Parametrised multi-port integer register file for the pipelined RISC-V core. Sits between decode (read/reserve) and writeback (write).
- Adds NREAD read ports, NWRITE write ports, write-to-read bypass, an optional hardwired zero register, and a per-register busy scoreboard. Decode uses the scoreboard to detect RAW hazards against in-flight producers.
- All state updates on posedge clk. The x0 write-on-negedge scheme is retired.

---
 rtl/regfile_pkg.sv | 29 ++
 rtl/regfile_scoreboard.sv | 76 +++++++
 rtl/regfile_mp.sv | 99 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port integer register file.
//   XLEN_DEF / NREG_DEF : default data width and register count
//   addr_width()        : ceil(log2(n)), at least 1, used to size address fields
//   xlen_t / regaddr_t  : data word and register index at the default sizes
//   ZERO_ADDR           : index of the hardwired zero register
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    function automatic int addr_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    localparam int AW_DEF = addr_width(NREG_DEF);

    typedef logic [XLEN_DEF-1:0] xlen_t;
    typedef logic [AW_DEF-1:0]   regaddr_t;

    localparam regaddr_t ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard for RAW hazard detection.
//   clk, rst_n    : clock, asynchronous active-high reset
//   wr_en_i       : per write port enable (a write retires its register)
//   wr_addr_i     : packed write addresses, port j at [j*AW +: AW]
//   rsv_en_i      : reserve rsv_addr_i at the next edge
//   rsv_addr_i    : register being reserved by decode
//   busy_o        : registered busy bit per register
//   busy_cnt_o    : registered population count of busy_o
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREG     = NREG_DEF,
    parameter  int NWRITE   = 1,
    parameter  int ZERO_REG = 1,
    localparam int AW       = addr_width(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NWRITE-1:0]    wr_en_i,
    input  logic [NWRITE*AW-1:0] wr_addr_i,
    input  logic                 rsv_en_i,
    input  logic [AW-1:0]        rsv_addr_i,
    output logic [NREG-1:0]      busy_o,
    output logic [AW:0]          busy_cnt_o
);

    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic [AW:0]     cnt_reg;
    logic [AW:0]     cnt_next;

    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
        logic set_hit;
        logic clr_hit;

        assign set_hit = rsv_en_i && (rsv_addr_i == AW'(gi));

        always_comb begin
            clr_hit = 1'b0;
            for (int j = 0; j < NWRITE; j++) begin
                if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == AW'(gi))) begin
                    clr_hit = 1'b1;
                end
            end
        end

        // Reserve beats retire: the new producer is still in flight.
        if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
            assign busy_next[gi] = 1'b0;
        end else begin : g_norm
            assign busy_next[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : busy_reg[gi]);
        end
    end

    // Count is taken from the next-state vector so it lands on the same edge.
    always_comb begin
        cnt_next = '0;
        for (int r = 0; r < NREG; r++) begin
            cnt_next = cnt_next + {{AW{1'b0}}, busy_next[r]};
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            busy_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            busy_reg <= busy_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign busy_o     = busy_reg;
    assign busy_cnt_o = cnt_reg;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write bypass and busy scoreboard.
//   clk, rst_n  : clock, asynchronous active-high reset
//   rd_addr_i   : packed read addresses, port k at [k*AW +: AW]
//   rd_data_o   : packed combinational read data
//   rd_busy_o   : registered busy bit of each read address (never bypassed)
//   wr_en_i     : per write port enable
//   wr_addr_i   : packed write addresses
//   wr_data_i   : packed write data
//   rsv_en_i    : reserve rsv_addr_i at the next edge
//   rsv_addr_i  : register to reserve
//   busy_cnt_o  : number of busy registers
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NREG     = NREG_DEF,
    parameter  int NREAD    = 2,
    parameter  int NWRITE   = 1,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = addr_width(NREG)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREAD*AW-1:0]    rd_addr_i,
    output logic [NREAD*XLEN-1:0]  rd_data_o,
    output logic [NREAD-1:0]       rd_busy_o,
    input  logic [NWRITE-1:0]      wr_en_i,
    input  logic [NWRITE*AW-1:0]   wr_addr_i,
    input  logic [NWRITE*XLEN-1:0] wr_data_i,
    input  logic                   rsv_en_i,
    input  logic [AW-1:0]          rsv_addr_i,
    output logic [AW:0]            busy_cnt_o
);

    logic [XLEN-1:0] regs_reg [NREG];
    logic [NREG-1:0] busy_vec;

    // Ports are applied in ascending order, so the highest enabled port
    // to a given address is the one that lands.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_reg[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wr_en_i[j] &&
                    !((ZERO_REG != 0) && (wr_addr_i[j*AW +: AW] == AW'(ZERO_ADDR)))) begin
                    regs_reg[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy;

        assign addr = rd_addr_i[gi*AW +: AW];

        always_comb begin
            data = regs_reg[addr];
            busy = busy_vec[addr];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWRITE; j++) begin
                    if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == addr)) begin
                        data = wr_data_i[j*XLEN +: XLEN];
                    end
                end
            end
            // Zero register and reset both override bypassed data.
            if (((ZERO_REG != 0) && (addr == AW'(ZERO_ADDR))) || rst_n) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign rd_data_o[gi*XLEN +: XLEN] = data;
        assign rd_busy_o[gi]              = busy;
    end

    regfile_scoreboard #(
        .NREG     (NREG),
        .NWRITE   (NWRITE),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .rsv_en_i   (rsv_en_i),
        .rsv_addr_i (rsv_addr_i),
        .busy_o     (busy_vec),
        .busy_cnt_o (busy_cnt_o)
    );

endmodule
